uart_xcvr: RTL and testbench
============================

UART_XCVR -- requirements
Module: uart_xcvr

Interface
REQ-001 Parameter SIZE, default 8: data bits per frame, legal range 5..9.
REQ-002 Parameter BAUD_COUNT, default 9: clk cycles per bit, minimum 4.
REQ-003 Parameter STOP_BITS, default 1: stop bits transmitted, 1 or 2.
REQ-004 Parameter PARITY_ODD, default 0: 0 selects even parity, 1 selects odd parity; used only when parity is compiled in.
REQ-005 Port clk, input, 1: single clock for all logic.
REQ-006 Port rst, input, 1: reset, asynchronous, active-high.
REQ-007 Port data_in, input, SIZE: byte to transmit.
REQ-008 Port tx_en, input, 1: transmit request.
REQ-009 Port rx, input, 1: serial receive line, asynchronous to clk.
REQ-010 Port loopback, input, 1: 1 routes internal tx to the receiver and ignores rx.
REQ-011 Port tx, output, 1: serial transmit line, idle high.
REQ-012 Port tx_busy, output, 1: transmitter frame in progress.
REQ-013 Port data_out, output, SIZE: last received word.
REQ-014 Port rx_done, output, 1: one-cycle pulse when a frame is received.
REQ-015 Port frame_err, output, 1: one-cycle pulse coincident with rx_done when the stop bit samples low.
REQ-016 Port parity_err, output, 1: one-cycle pulse coincident with rx_done on parity mismatch; tied 0 when parity is compiled out.

Function
REQ-017 TX FSM SHALL use states IDLE, START, DATA, PARITY, STOP; each bit lasts exactly BAUD_COUNT cycles.
REQ-018 In IDLE with tx_en=1, TX SHALL latch data_in, raise tx_busy and drive tx low on the next edge.
REQ-019 tx_en while tx_busy=1 SHALL be ignored; no queuing.
REQ-020 Data SHALL be sent LSB first, followed by the parity bit (if compiled in) and then STOP_BITS high bits.
REQ-021 tx_busy SHALL fall on the edge the last stop bit completes, so tx_en asserted in that cycle starts a new frame with no idle gap.
REQ-022 The RX input SHALL pass through a 2-flop synchroniser; loopback selects the input ahead of the synchroniser and may change only while both FSMs are idle.
REQ-023 RX FSM SHALL use states IDLE, START, DATA, PARITY, STOP, BREAK.
REQ-024 In IDLE, a synchronised high-to-low transition SHALL enter START; the line is sampled at count BAUD_COUNT/2 (integer), and a high sample there returns the FSM to IDLE with no pulse.
REQ-025 Subsequent bits SHALL be sampled every BAUD_COUNT cycles from the start-bit midpoint.
REQ-026 At the first stop-bit sample, data_out SHALL update and rx_done SHALL pulse; frame_err and parity_err SHALL pulse in the same cycle when the condition holds.
REQ-027 A low stop-bit sample SHALL enter BREAK, which waits for a high line before returning to IDLE.
REQ-028 RX SHALL check one stop bit only, regardless of STOP_BITS.
REQ-029 TX and RX SHALL operate concurrently and independently.

Reset
REQ-030 While rst=1: tx=1, tx_busy=0, data_out=0, rx_done=0, frame_err=0, parity_err=0, both FSMs in IDLE, counters 0, synchroniser flops 1.
REQ-031 rst asserted mid-frame SHALL abort both frames immediately; the partial RX word SHALL not reach data_out.

Configuration
REQ-032 Macro UART_PARITY_EN defined: a PARITY state and bit are added to TX and RX, with polarity set by PARITY_ODD.
REQ-033 Macro UART_PARITY_EN undefined: no parity bit; PARITY states are unreachable or removed; parity_err is constant 0.

Structure
REQ-034 Package uart_pkg SHALL hold the tx_state_t and rx_state_t enums and the parity helper function.
REQ-035 Sub-module uart_baud_cnt (BAUD_COUNT-period counter with clear input and tick output) SHALL be instantiated once for TX and once for RX.

Verification
REQ-036 Loopback=1, SIZE=8, data_in=8'hA5, one tx_en pulse -> rx_done pulses once with data_out=8'hA5, frame_err=0, tx_busy high for 10*9=90 cycles (parity off).
REQ-037 tx_en held high across 3 frames with data 8'h00, 8'hFF, 8'h3C -> frames back-to-back with no idle cycles, 3 rx_done pulses, data in order.
REQ-038 Drive rx low for 2 cycles only -> no rx_done and RX returns to IDLE (false start).
REQ-039 Drive rx frame 8'h55 with a low stop bit -> rx_done and frame_err pulse together, data_out=8'h55, RX holds in BREAK until rx goes high.
REQ-040 UART_PARITY_EN, even parity, rx frame 8'h01 with parity bit 0 -> parity_err=1; with parity bit 1 -> parity_err=0.
REQ-041 rst pulsed in the middle of the DATA state -> tx=1, tx_busy=0, no rx_done, and the next frame is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM state types and the parity helper for the UART transceiver.
package uart_pkg;

  // Widest data word supported by uart_xcvr.
  localparam int unsigned MAX_SIZE = 9;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP,
    RX_BREAK
  } rx_state_t;

  // Parity bit over a zero-extended word; odd=0 gives even parity.
  function automatic logic parity_bit(input logic [MAX_SIZE-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// uart_baud_cnt: free-running bit-period counter, 0..BAUD_COUNT-1, synchronous clear.
module uart_baud_cnt #(
  parameter int unsigned BAUD_COUNT = 9,
  parameter int unsigned CW         = $clog2(BAUD_COUNT)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  output logic [CW-1:0] cnt,
  output logic          tick_c
);

  localparam logic [CW-1:0] LAST = CW'(BAUD_COUNT - 1);

  assign tick_c = (cnt == LAST);

  // Count one bit period, wrapping on the last cycle or restarting on clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr || tick_c) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/uart_xcvr.sv
// uart_xcvr: full-duplex UART transmitter/receiver with internal loopback.
// Define UART_PARITY_EN to add a parity bit to both directions (PARITY_ODD selects polarity).
module uart_xcvr
  import uart_pkg::*;
#(
  parameter int unsigned SIZE       = 8,
  parameter int unsigned BAUD_COUNT = 9,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [SIZE-1:0] data_in,
  input  logic            tx_en,
  input  logic            rx,
  input  logic            loopback,
  output logic            tx,
  output logic            tx_busy,
  output logic [SIZE-1:0] data_out,
  output logic            rx_done,
  output logic            frame_err,
  output logic            parity_err
);

  localparam int unsigned   CW        = $clog2(BAUD_COUNT);
  localparam int unsigned   IW        = $clog2(SIZE);
  localparam logic [IW-1:0] LAST_BIT  = IW'(SIZE - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic [CW-1:0] MID_CNT   = CW'(BAUD_COUNT / 2);

  // ---------------------------------------------------------------- TX
  tx_state_t       tx_state, tx_state_nx;
  logic [IW-1:0]   tx_idx, tx_idx_nx;
  logic            tx_stop, tx_stop_nx;
  logic [SIZE-1:0] tx_word, tx_word_nx;
  logic            tx_bit_c, tx_busy_c;
  logic            tx_clr_c, tx_tick_c;
  logic [CW-1:0]   tx_cnt_unused;

  assign tx_clr_c = (tx_state == TX_IDLE);

  uart_baud_cnt #(.BAUD_COUNT(BAUD_COUNT), .CW(CW)) u_tx_baud (
    .clk    (clk),
    .rst    (rst),
    .clr    (tx_clr_c),
    .cnt    (tx_cnt_unused),
    .tick_c (tx_tick_c)
  );

  // TX state, bit counters and latched word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state <= TX_IDLE;
      tx_idx   <= '0;
      tx_stop  <= 1'b0;
      tx_word  <= '0;
      tx       <= 1'b1;
      tx_busy  <= 1'b0;
    end else begin
      tx_state <= tx_state_nx;
      tx_idx   <= tx_idx_nx;
      tx_stop  <= tx_stop_nx;
      tx_word  <= tx_word_nx;
      tx       <= tx_bit_c;
      tx_busy  <= tx_busy_c;
    end
  end

  // TX next state; a request on the final stop tick chains straight into a new start bit.
  always_comb begin
    tx_state_nx = tx_state;
    tx_idx_nx   = tx_idx;
    tx_stop_nx  = tx_stop;
    tx_word_nx  = tx_word;
    unique case (tx_state)
      TX_IDLE: begin
        if (tx_en) begin
          tx_state_nx = TX_START;
          tx_word_nx  = data_in;
        end
      end
      TX_START: begin
        if (tx_tick_c) begin
          tx_state_nx = TX_DATA;
          tx_idx_nx   = '0;
        end
      end
      TX_DATA: begin
        if (tx_tick_c) begin
          if (tx_idx == LAST_BIT) begin
`ifdef UART_PARITY_EN
            tx_state_nx = TX_PARITY;
`else
            tx_state_nx = TX_STOP;
`endif
            tx_stop_nx = 1'b0;
          end else begin
            tx_idx_nx = tx_idx + IW'(1);
          end
        end
      end
`ifdef UART_PARITY_EN
      TX_PARITY: begin
        if (tx_tick_c) begin
          tx_state_nx = TX_STOP;
          tx_stop_nx  = 1'b0;
        end
      end
`endif
      TX_STOP: begin
        if (tx_tick_c) begin
          if (tx_stop == STOP_LAST) begin
            if (tx_en) begin
              tx_state_nx = TX_START;
              tx_word_nx  = data_in;
            end else begin
              tx_state_nx = TX_IDLE;
            end
          end else begin
            tx_stop_nx = 1'b1;
          end
        end
      end
      default: tx_state_nx = TX_IDLE;
    endcase
  end

  // TX line level and busy flag for the upcoming cycle.
  always_comb begin
    tx_bit_c  = 1'b1;
    tx_busy_c = 1'b1;
    unique case (tx_state_nx)
      TX_IDLE:   tx_busy_c = 1'b0;
      TX_START:  tx_bit_c  = 1'b0;
      TX_DATA:   tx_bit_c  = tx_word_nx[tx_idx_nx];
`ifdef UART_PARITY_EN
      TX_PARITY: tx_bit_c  = parity_bit(MAX_SIZE'(tx_word_nx), (PARITY_ODD != 0));
`endif
      default:   tx_bit_c  = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------- RX
  rx_state_t       rx_state, rx_state_nx;
  logic [IW-1:0]   rx_idx, rx_idx_nx;
  logic [SIZE-1:0] rx_sh;
  logic            rx_src_c, rx_s1, rx_s2, rx_prev;
  logic            rx_fall_c, rx_mid_c;
  logic            rx_clr_c, rx_tick_c;
  logic [CW-1:0]   rx_cnt;
  logic            rx_shift_c, rx_done_c, rx_ferr_c;
`ifdef UART_PARITY_EN
  logic            rx_par, rx_par_smp_c, rx_perr_c;
`else
  logic            parity_odd_unused;
  assign parity_odd_unused = (PARITY_ODD != 0);
`endif

  assign rx_src_c  = loopback ? tx : rx;
  assign rx_fall_c = rx_prev & ~rx_s2;
  assign rx_mid_c  = (rx_cnt == MID_CNT);

  uart_baud_cnt #(.BAUD_COUNT(BAUD_COUNT), .CW(CW)) u_rx_baud (
    .clk    (clk),
    .rst    (rst),
    .clr    (rx_clr_c),
    .cnt    (rx_cnt),
    .tick_c (rx_tick_c)
  );

  // Two-flop synchroniser plus one history flop for falling-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= rx_src_c;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  // RX state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state <= RX_IDLE;
      rx_idx   <= '0;
    end else begin
      rx_state <= rx_state_nx;
      rx_idx   <= rx_idx_nx;
    end
  end

  // RX next state; a low stop sample parks in BREAK until the line recovers.
  always_comb begin
    rx_state_nx = rx_state;
    rx_idx_nx   = rx_idx;
    unique case (rx_state)
      RX_IDLE: begin
        if (rx_fall_c) rx_state_nx = RX_START;
      end
      RX_START: begin
        if (rx_mid_c) begin
          rx_state_nx = rx_s2 ? RX_IDLE : RX_DATA;
          rx_idx_nx   = '0;
        end
      end
      RX_DATA: begin
        if (rx_tick_c) begin
          if (rx_idx == LAST_BIT) begin
`ifdef UART_PARITY_EN
            rx_state_nx = RX_PARITY;
`else
            rx_state_nx = RX_STOP;
`endif
          end else begin
            rx_idx_nx = rx_idx + IW'(1);
          end
        end
      end
`ifdef UART_PARITY_EN
      RX_PARITY: begin
        if (rx_tick_c) rx_state_nx = RX_STOP;
      end
`endif
      RX_STOP: begin
        if (rx_tick_c) rx_state_nx = rx_s2 ? RX_IDLE : RX_BREAK;
      end
      RX_BREAK: begin
        if (rx_s2) rx_state_nx = RX_IDLE;
      end
      default: rx_state_nx = RX_IDLE;
    endcase
  end

  // RX controls: counter restarts at the start midpoint so later samples land mid-bit.
  always_comb begin
    rx_clr_c   = 1'b1;
    rx_shift_c = 1'b0;
    rx_done_c  = 1'b0;
    rx_ferr_c  = 1'b0;
`ifdef UART_PARITY_EN
    rx_par_smp_c = 1'b0;
    rx_perr_c    = 1'b0;
`endif
    unique case (rx_state)
      RX_START: rx_clr_c = rx_mid_c;
      RX_DATA: begin
        rx_clr_c   = 1'b0;
        rx_shift_c = rx_tick_c;
      end
`ifdef UART_PARITY_EN
      RX_PARITY: begin
        rx_clr_c     = 1'b0;
        rx_par_smp_c = rx_tick_c;
      end
`endif
      RX_STOP: begin
        rx_clr_c  = 1'b0;
        rx_done_c = rx_tick_c;
        rx_ferr_c = rx_tick_c & ~rx_s2;
`ifdef UART_PARITY_EN
        rx_perr_c = rx_tick_c &
                    (rx_par != parity_bit(MAX_SIZE'(rx_sh), (PARITY_ODD != 0)));
`endif
      end
      default: rx_clr_c = 1'b1;
    endcase
  end

  // RX shift register and registered result pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_sh     <= '0;
      data_out  <= '0;
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (rx_shift_c) rx_sh <= {rx_s2, rx_sh[SIZE-1:1]};
      if (rx_done_c) data_out <= rx_sh;
      rx_done   <= rx_done_c;
      frame_err <= rx_ferr_c;
    end
  end

`ifdef UART_PARITY_EN
  // Received parity bit and mismatch pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_par     <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      if (rx_par_smp_c) rx_par <= rx_s2;
      parity_err <= rx_perr_c;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_xcvr.sv
// tb_uart_xcvr: randomized self-checking bench for uart_xcvr against a frame-level model.
module tb_uart_xcvr;

  localparam int unsigned SIZE = 8;
  localparam int unsigned B    = 9;
  localparam int unsigned STOP = 1;
  localparam int unsigned ODD  = 0;
`ifdef UART_PARITY_EN
  localparam int unsigned PBITS = 1;
`else
  localparam int unsigned PBITS = 0;
`endif
  localparam int FB = int'((1 + SIZE + PBITS + STOP) * B);

  typedef struct packed {
    logic            fe;
    logic            pe;
    logic [SIZE-1:0] d;
  } rec_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [SIZE-1:0] data_in = '0;
  logic            tx_en = 1'b0;
  logic            rx = 1'b1;
  logic            loopback = 1'b0;
  logic            tx, tx_busy, rx_done, frame_err, parity_err;
  logic [SIZE-1:0] data_out;

  int              n_cmp = 0;
  int              n_bad = 0;
  rec_t            rx_log[$];
  logic [SIZE-1:0] wq[$];
  logic            done_prev = 1'b0;
`ifdef UART_PARITY_EN
  logic            par_bad = 1'b0;
`endif

  uart_xcvr #(
    .SIZE(SIZE), .BAUD_COUNT(B), .STOP_BITS(STOP), .PARITY_ODD(ODD)
  ) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .tx_en(tx_en), .rx(rx),
    .loopback(loopback), .tx(tx), .tx_busy(tx_busy), .data_out(data_out),
    .rx_done(rx_done), .frame_err(frame_err), .parity_err(parity_err)
  );

  always #5 clk = ~clk;

`ifdef UART_PARITY_EN
  // Parity bit the line should carry for word w.
  function automatic logic model_parity(input logic [SIZE-1:0] w);
    return ((($countones(w) + ODD) % 2) == 1);
  endfunction
`endif

  // Expected tx level k cycles into the frame carrying word w.
  function automatic logic frame_bit(input logic [SIZE-1:0] w, input int k);
    int i;
    i = k / int'(B);
    if (i == 0) return 1'b0;
    if (i <= int'(SIZE)) return w[i-1];
`ifdef UART_PARITY_EN
    if (i == int'(SIZE) + 1) return model_parity(w);
`endif
    return 1'b1;
  endfunction

  // Log every received frame; error pulses must coincide with rx_done.
  always @(negedge clk) begin
    if (rx_done || frame_err || parity_err) begin
      n_cmp++;
      if (rx_done !== 1'b1) begin
        n_bad++;
        $display("FAIL err_pulse: rx_done=%b frame_err=%b parity_err=%b required rx_done=1",
                 rx_done, frame_err, parity_err);
      end else begin
        rx_log.push_back('{fe: frame_err, pe: parity_err, d: data_out});
      end
    end
    if (rx_done && done_prev) begin
      n_cmp++;
      n_bad++;
      $display("FAIL rx_done_width: high 2 cycles, required 1");
    end
    done_prev = rx_done;
  end

  // Transmit wq[0..n-1] in loopback, checking the line cycle by cycle and the received words.
  task automatic tx_burst(input int n, input bit b2b);
    logic et, eb;
    rec_t exp_r;
    rx_log.delete();
    @(negedge clk);
    data_in = wq[0];
    tx_en   = 1'b1;
    for (int c = 0; c <= n * FB; c++) begin
      @(negedge clk);
      if (c < n * FB) begin
        et = frame_bit(wq[c / FB], c % FB);
        eb = 1'b1;
      end else begin
        et = 1'b1;
        eb = 1'b0;
      end
      n_cmp += 2;
      if (tx !== et) begin
        n_bad++;
        $display("FAIL tx_line: cycle %0d tx=%b required %b", c, tx, et);
      end
      if (tx_busy !== eb) begin
        n_bad++;
        $display("FAIL tx_busy: cycle %0d tx_busy=%b required %b", c, tx_busy, eb);
      end
      if (b2b) begin
        if ((c % FB) == 0 && (c / FB) + 1 < n) data_in = wq[c / FB + 1];
        if (c == n * FB - 1) tx_en = 1'b0;
      end else begin
        tx_en   = (c == FB / 2);
        data_in = SIZE'($urandom);
      end
    end
    repeat (B) @(negedge clk);
    n_cmp++;
    if (rx_log.size() != n) begin
      n_bad++;
      $display("FAIL rx_count: got %0d frames required %0d", rx_log.size(), n);
    end
    for (int i = 0; i < n && i < rx_log.size(); i++) begin
      exp_r = '{fe: 1'b0, pe: 1'b0, d: wq[i]};
      n_cmp++;
      if (rx_log[i] !== exp_r) begin
        n_bad++;
        $display("FAIL rx_word[%0d]: got %h required %h", i, rx_log[i], exp_r);
      end
    end
  endtask

  // Drive one frame onto rx; the line is left at the stop level.
  task automatic drive_rx(input logic [SIZE-1:0] w, input logic sbit);
    rx = 1'b0;
    repeat (B) @(negedge clk);
    for (int i = 0; i < int'(SIZE); i++) begin
      rx = w[i];
      repeat (B) @(negedge clk);
    end
`ifdef UART_PARITY_EN
    rx = model_parity(w) ^ par_bad;
    repeat (B) @(negedge clk);
`endif
    rx = sbit;
    repeat (B) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp += 6;
    if (tx !== 1'b1)        begin n_bad++; $display("FAIL reset_tx: got %b required 1", tx); end
    if (tx_busy !== 1'b0)   begin n_bad++; $display("FAIL reset_busy: got %b required 0", tx_busy); end
    if (data_out !== '0)    begin n_bad++; $display("FAIL reset_data: got %h required 0", data_out); end
    if (rx_done !== 1'b0)   begin n_bad++; $display("FAIL reset_done: got %b required 0", rx_done); end
    if (frame_err !== 1'b0) begin n_bad++; $display("FAIL reset_ferr: got %b required 0", frame_err); end
    if (parity_err !== 1'b0) begin n_bad++; $display("FAIL reset_perr: got %b required 0", parity_err); end
    rst = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_loopback_single();
    loopback = 1'b1;
    wq.delete();
    wq.push_back(SIZE'(8'hA5));
    tx_burst(1, 1'b0);
  endtask

  task automatic test_back_to_back();
    wq.delete();
    wq.push_back(SIZE'(8'h00));
    wq.push_back(SIZE'(8'hFF));
    wq.push_back(SIZE'(8'h3C));
    tx_burst(3, 1'b1);
  endtask

  task automatic test_random();
    for (int k = 0; k < 5; k++) begin
      wq.delete();
      wq.push_back(SIZE'($urandom));
      tx_burst(1, 1'b0);
      repeat ($urandom_range(1, 20)) @(negedge clk);
    end
    wq.delete();
    for (int k = 0; k < 4; k++) wq.push_back(SIZE'($urandom));
    tx_burst(4, 1'b1);
  endtask

  task automatic test_false_start();
    logic [SIZE-1:0] w;
    rec_t exp_r;
    loopback = 1'b0;
    rx = 1'b1;
    repeat (4) @(negedge clk);
    rx_log.delete();
    rx = 1'b0;
    repeat (2) @(negedge clk);
    rx = 1'b1;
    repeat (2 * FB) @(negedge clk);
    n_cmp++;
    if (rx_log.size() != 0) begin
      n_bad++;
      $display("FAIL false_start: got %0d frames required 0", rx_log.size());
    end
    w = SIZE'($urandom);
    drive_rx(w, 1'b1);
    repeat (B) @(negedge clk);
    exp_r = '{fe: 1'b0, pe: 1'b0, d: w};
    n_cmp++;
    if (rx_log.size() != 1 || rx_log[0] !== exp_r) begin
      n_bad++;
      $display("FAIL after_false_start: got %0d frames first %h required 1 frame %h",
               rx_log.size(), (rx_log.size() > 0) ? rx_log[0] : '0, exp_r);
    end
  endtask

  task automatic test_frame_error();
    logic [SIZE-1:0] w;
    rec_t exp_r;
    rx_log.delete();
    w = SIZE'(8'h55);
    drive_rx(w, 1'b0);
    repeat (3 * B) @(negedge clk);
    exp_r = '{fe: 1'b1, pe: 1'b0, d: w};
    n_cmp += 2;
    if (rx_log.size() != 1 || rx_log[0] !== exp_r) begin
      n_bad++;
      $display("FAIL frame_err: got %0d frames first %h required 1 frame %h",
               rx_log.size(), (rx_log.size() > 0) ? rx_log[0] : '0, exp_r);
    end
    if (data_out !== w) begin
      n_bad++;
      $display("FAIL break_hold: data_out=%h required %h", data_out, w);
    end
    rx = 1'b1;
    repeat (2 * B) @(negedge clk);
    rx_log.delete();
    w = SIZE'($urandom);
    drive_rx(w, 1'b1);
    repeat (B) @(negedge clk);
    exp_r = '{fe: 1'b0, pe: 1'b0, d: w};
    n_cmp++;
    if (rx_log.size() != 1 || rx_log[0] !== exp_r) begin
      n_bad++;
      $display("FAIL after_break: got %0d frames first %h required 1 frame %h",
               rx_log.size(), (rx_log.size() > 0) ? rx_log[0] : '0, exp_r);
    end
  endtask

`ifdef UART_PARITY_EN
  task automatic test_parity();
    logic [SIZE-1:0] w;
    logic            pbit;
    rec_t            exp_r;
    for (int k = 0; k < 6; k++) begin
      if (k < 2) begin
        w    = SIZE'(8'h01);
        pbit = 1'(k);
      end else begin
        w    = SIZE'($urandom);
        pbit = 1'($urandom);
      end
      par_bad = pbit ^ model_parity(w);
      rx_log.delete();
      drive_rx(w, 1'b1);
      repeat (B) @(negedge clk);
      exp_r = '{fe: 1'b0, pe: (pbit != model_parity(w)), d: w};
      n_cmp++;
      if (rx_log.size() != 1 || rx_log[0] !== exp_r) begin
        n_bad++;
        $display("FAIL parity[%0d]: got %0d frames first %h required 1 frame %h", k,
                 rx_log.size(), (rx_log.size() > 0) ? rx_log[0] : '0, exp_r);
      end
    end
    par_bad = 1'b0;
  endtask
`endif

  task automatic test_reset_midframe();
    loopback = 1'b1;
    repeat (2) @(negedge clk);
    rx_log.delete();
    data_in = SIZE'($urandom);
    tx_en   = 1'b1;
    @(negedge clk);
    tx_en = 1'b0;
    repeat (3 * B + 2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_cmp += 4;
    if (tx !== 1'b1)      begin n_bad++; $display("FAIL midrst_tx: got %b required 1", tx); end
    if (tx_busy !== 1'b0) begin n_bad++; $display("FAIL midrst_busy: got %b required 0", tx_busy); end
    if (rx_done !== 1'b0) begin n_bad++; $display("FAIL midrst_done: got %b required 0", rx_done); end
    if (data_out !== '0)  begin n_bad++; $display("FAIL midrst_data: got %h required 0", data_out); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2 * FB) @(negedge clk);
    n_cmp += 2;
    if (rx_log.size() != 0) begin
      n_bad++;
      $display("FAIL midrst_partial: got %0d frames required 0", rx_log.size());
    end
    if (tx_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL midrst_idle: tx_busy=%b required 0", tx_busy);
    end
    wq.delete();
    wq.push_back(SIZE'($urandom));
    tx_burst(1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_loopback_single();
    test_back_to_back();
    test_random();
    test_false_start();
    test_frame_error();
`ifdef UART_PARITY_EN
    test_parity();
`endif
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
